wb_slave_ctrl: RTL

Registered Wishbone-classic slave controller between the management-SoC Wishbone port (wb_clk_i domain) and up to NSLV user-area slaves (user logic, debug registers, GPIO test registers). It decodes one index field of wbs_adr_i, sequences a single outstanding transaction to the selected slave, returns the registered ack/data to the master, and reports decode and timeout errors.

---
 rtl/wb_slave_ctrl_pkg.sv | 19 +
 rtl/wb_slave_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_ctrl_pkg.sv
// Shared types and constants for the Wishbone slave controller.
// The optional timeout is compiled in with the WB_SLAVE_TIMEOUT_EN macro.
package wb_slave_ctrl_pkg;

    localparam int WB_DW  = 32;
    localparam int WB_SW  = 4;
    localparam int WAIT_W = 16;

    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        ERR,
        HOLD
    } state_e;

endpackage

// File: rtl/wb_slave_ctrl.sv
// Registered Wishbone-classic slave controller fanning one master out to NSLV slaves.
// Define WB_SLAVE_TIMEOUT_EN to add the wait-state timeout counter.
module wb_slave_ctrl
    import wb_slave_ctrl_pkg::*;
#(
    parameter int               NSLV     = 4,
    parameter int               SEL_LO   = 3,
    parameter int               SEL_W    = 2,
    parameter int               TIMEOUT  = 255,
    parameter logic [WB_DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [WB_SW-1:0]      wbs_sel_i,
    input  logic [WB_DW-1:0]      wbs_adr_i,
    input  logic [WB_DW-1:0]      wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [WB_DW-1:0]      wbs_dat_o,
    output logic [NSLV-1:0]       slv_cyc_o,
    output logic [NSLV-1:0]       slv_stb_o,
    output logic                  slv_we_o,
    output logic [WB_SW-1:0]      slv_sel_o,
    output logic [WB_DW-1:0]      slv_adr_o,
    output logic [WB_DW-1:0]      slv_dat_o,
    input  logic [NSLV-1:0]       slv_ack_i,
    input  logic [WB_DW*NSLV-1:0] slv_dat_i,
    output logic                  err_irq_o,
    output logic [7:0]            err_cnt_o
);

    if (NSLV < 1 || NSLV > 8 || (1 << SEL_W) < NSLV || TIMEOUT < 1 || TIMEOUT > 65535)
    begin : g_param_chk
        $error("wb_slave_ctrl: illegal parameter combination");
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic [WB_DW-1:0] adr_q, adr_d;
    logic [WB_DW-1:0] wdat_q, wdat_d;
    logic [WB_DW-1:0] rdat_q, rdat_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0] req_idx;
    logic [NSLV-1:0]  idx_oh;
    logic [WB_DW-1:0] slv_rdat;
    logic             ack_sel;
    logic             stb_en;
    logic             tmo;

    assign req_idx = wbs_adr_i[SEL_LO +: SEL_W];

    always_comb begin
        idx_oh   = '0;
        slv_rdat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (int'(idx_q) == k) begin
                idx_oh[k] = 1'b1;
                slv_rdat  = slv_dat_i[WB_DW*k +: WB_DW];
            end
        end
    end

    // Only the latched target's ack counts; others are ignored even if asserted.
    assign ack_sel = |(slv_ack_i & idx_oh);

`ifdef WB_SLAVE_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;

    // wait_q holds the number of REQ cycles already completed.
    assign tmo = (state_q == REQ) && (wait_q == WAIT_W'(TIMEOUT));

    always_comb begin
        wait_d = '0;
        if (state_q == REQ) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Strobes fall combinationally on master abort or timeout.
    assign stb_en    = (state_q == REQ) && wbs_cyc_i && !tmo;
    assign slv_cyc_o = stb_en ? idx_oh : '0;
    assign slv_stb_o = stb_en ? idx_oh : '0;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    adr_d  = wbs_adr_i;
                    wdat_d = wbs_dat_i;
                    idx_d  = req_idx;
                    if (int'(req_idx) < NSLV) begin
                        state_d = REQ;
                    end else begin
                        state_d   = ERR;
                        rdat_d    = ERR_DATA;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
            end
            REQ: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (ack_sel) begin
                    state_d = RESP;
                    rdat_d  = slv_rdat;
                end else if (tmo) begin
                    state_d   = ERR;
                    rdat_d    = ERR_DATA;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
            RESP:    state_d = HOLD;
            ERR:     state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wbs_ack_o = (state_q == RESP) || (state_q == ERR);
    assign wbs_dat_o = rdat_q;
    assign err_irq_o = (state_q == ERR);
    assign err_cnt_o = err_cnt_q;
    assign slv_we_o  = we_q;
    assign slv_sel_o = sel_q;
    assign slv_adr_o = adr_q;
    assign slv_dat_o = wdat_q;

endmodule
